// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU write-back trace writer.
// Holds default record field widths, record kind codes, the marker
// register fill bit and the writer control state encoding.
package cpu_trace_pkg;

    localparam int unsigned TRACE_DATA_W = 16;
    localparam int unsigned TRACE_REG_W  = 4;
    localparam int unsigned TRACE_CYC_W  = 16;
    localparam int unsigned TRACE_DEPTH  = 8;
    localparam int unsigned DROP_W       = 8;

    // Record kind: normal write-back event or end-of-trace marker
    localparam logic KIND_EVENT  = 1'b0;
    localparam logic KIND_MARKER = 1'b1;

    // Fill bit replicated across the register field of the end marker
    localparam logic MARKER_REG = 1'b1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MARK  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } trace_state_e;

endpackage

// File: rtl/trace_fifo_2w1r.sv
// Show-ahead FIFO with two ordered write ports and one read port.
// Ports:
//   clock, reset     rising-edge clock, async active-low reset
//   w0_en/w0_data    first record written this edge
//   w1_en/w1_data    second record, written behind w0 (only with w0_en)
//   rd_en            pop the head entry (caller ensures head_valid)
//   head_valid       registered: queue not empty
//   head_data        registered: head entry, zero when empty
//   count            registered occupancy 0..DEPTH
// Callers must only write into free space counted before the edge.
module trace_fifo_2w1r #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     w0_en,
    input  logic [W-1:0]             w0_data,
    input  logic                     w1_en,
    input  logic [W-1:0]             w1_data,
    input  logic                     rd_en,
    output logic                     head_valid,
    output logic [W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_next;
    logic [AW-1:0] wr_next;
    logic [AW-1:0] wr_ptr1;
    logic [CW-1:0] count_next;
    logic [W-1:0]  head_next;

    // Next pointers/occupancy and the head that will be visible after the edge
    always_comb begin
        wr_ptr1    = wr_ptr + AW'(1);
        rd_next    = rd_ptr + AW'(rd_en);
        wr_next    = wr_ptr + AW'(w0_en) + AW'(w1_en);
        count_next = count + CW'(w0_en) + CW'(w1_en) - CW'(rd_en);
        head_next  = '0;
        if (count_next != '0) begin
            // All older entries gone: the new head is the record being written now
            if (w0_en && (rd_next == wr_ptr)) begin
                head_next = w0_data;
            end else begin
                head_next = mem[rd_next];
            end
        end
    end

    // Storage: contents need no reset, validity is tracked by the pointers
    always_ff @(posedge clock) begin
        if (w0_en) begin
            mem[wr_ptr] <= w0_data;
        end
        if (w1_en) begin
            mem[wr_ptr1] <= w1_data;
        end
    end

    // Pointers, occupancy and registered head
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            rd_ptr     <= rd_next;
            wr_ptr     <= wr_next;
            count      <= count_next;
            head_valid <= (count_next != '0);
            head_data  <= head_next;
        end
    end

endmodule

// File: rtl/cpu_wb_trace_writer.sv
// CPU write-back trace writer: stamps write-back events with a cycle count,
// queues them and streams them out on a valid/ready port. On halt it appends
// an end marker carrying the drop count, drains, then raises done.
// Ports:
//   clock, reset            rising-edge clock, async active-low reset
//   wb_we/wb_reg/wb_data    register write-back event
//   wb_r0_we/wb_r0_data     R0 result write event
//   halt                    CPU halted (level)
//   trace_valid/ready/data  show-ahead record stream {kind, cycle, reg, data}
//   level                   queue occupancy
//   overflow                sticky: an event was dropped
//   done                    end marker consumed and queue empty
module cpu_wb_trace_writer
    import cpu_trace_pkg::*;
#(
    parameter int unsigned DATA_W = TRACE_DATA_W,
    parameter int unsigned REG_W  = TRACE_REG_W,
    parameter int unsigned CYC_W  = TRACE_CYC_W,
    parameter int unsigned DEPTH  = TRACE_DEPTH
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             wb_we,
    input  logic [REG_W-1:0]                 wb_reg,
    input  logic [DATA_W-1:0]                wb_data,
    input  logic                             wb_r0_we,
    input  logic [DATA_W-1:0]                wb_r0_data,
    input  logic                             halt,
    output logic                             trace_valid,
    input  logic                             trace_ready,
    output logic [CYC_W+REG_W+DATA_W:0]      trace_data,
    output logic [$clog2(DEPTH):0]           level,
    output logic                             overflow,
    output logic                             done
);

    localparam int unsigned REC_W = 1 + CYC_W + REG_W + DATA_W;
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W = DROP_W + 1;

    trace_state_e state_q;
    trace_state_e state_d;

    logic [CYC_W-1:0]  cyc_q;
    logic [DROP_W-1:0] drop_q;
    logic              overflow_q;
    logic              done_q;

    logic              w0_en;
    logic              w1_en;
    logic              rd_en;
    logic [REC_W-1:0]  w0_data;
    logic [REC_W-1:0]  w1_data;
    logic [REC_W-1:0]  rec_wb;
    logic [REC_W-1:0]  rec_r0;
    logic [REC_W-1:0]  rec_mark;
    logic [LVL_W-1:0]  free_c;
    logic [1:0]        n_drop;
    logic [SUM_W-1:0]  drop_sum;

    logic              fifo_valid;
    logic [REC_W-1:0]  fifo_data;
    logic [LVL_W-1:0]  fifo_count;

    // Space is judged on occupancy before the edge; a same-edge pop does not help
    assign free_c   = LVL_W'(DEPTH) - fifo_count;
    assign rec_wb   = {KIND_EVENT, cyc_q, wb_reg, wb_data};
    assign rec_r0   = {KIND_EVENT, cyc_q, {REG_W{1'b0}}, wb_r0_data};
    assign rec_mark = {KIND_MARKER, cyc_q, {REG_W{MARKER_REG}}, DATA_W'(drop_q)};
    assign rd_en    = fifo_valid & trace_ready & (state_q != DONE);
    assign drop_sum = {1'b0, drop_q} + SUM_W'(n_drop);

    // Next state, push arbitration and drop accounting
    always_comb begin
        state_d = state_q;
        w0_en   = 1'b0;
        w0_data = '0;
        w1_en   = 1'b0;
        w1_data = '0;
        n_drop  = 2'd0;
        case (state_q)
            RUN: begin
                if (wb_we && wb_r0_we) begin
                    // Register write goes first, R0 result behind it
                    if (free_c >= LVL_W'(2)) begin
                        w0_en   = 1'b1;
                        w0_data = rec_wb;
                        w1_en   = 1'b1;
                        w1_data = rec_r0;
                    end else if (free_c == LVL_W'(1)) begin
                        w0_en   = 1'b1;
                        w0_data = rec_wb;
                        n_drop  = 2'd1;
                    end else begin
                        n_drop  = 2'd2;
                    end
                end else if (wb_we || wb_r0_we) begin
                    if (free_c != '0) begin
                        w0_en   = 1'b1;
                        w0_data = wb_we ? rec_wb : rec_r0;
                    end else begin
                        n_drop  = 2'd1;
                    end
                end
                if (halt) begin
                    state_d = MARK;
                end
            end
            MARK: begin
                if (free_c != '0) begin
                    w0_en   = 1'b1;
                    w0_data = rec_mark;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_count == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
        endcase
    end

    // State, cycle stamp, saturating drop count and status flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            cyc_q      <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == RUN) begin
                cyc_q <= cyc_q + CYC_W'(1);
            end
            drop_q <= drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
            if (n_drop != 2'd0) begin
                overflow_q <= 1'b1;
            end
            done_q <= (state_d == DONE);
        end
    end

    trace_fifo_2w1r #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .w0_en      (w0_en),
        .w0_data    (w0_data),
        .w1_en      (w1_en),
        .w1_data    (w1_data),
        .rd_en      (rd_en),
        .head_valid (fifo_valid),
        .head_data  (fifo_data),
        .count      (fifo_count)
    );

    assign trace_valid = fifo_valid;
    assign trace_data  = fifo_data;
    assign level       = fifo_count;
    assign overflow    = overflow_q;
    assign done        = done_q;

endmodule
